// File: rtl/axis_capture_mem.sv
// axis_capture_mem: AXI-Stream frame sink that captures one frame into on-chip memory
// and exposes a registered random-access read port.
module axis_capture_mem #(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    s00_axis_aclk,
  input  logic                    s00_axis_aresetn,
  input  logic                    s00_axis_enable,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    frame_done,
  output logic [ADDR_WIDTH:0]     frame_len,
  output logic                    overflow
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] wdata;
  logic beat;
  assign s00_axis_tready = state == CAPTURE;
  assign beat = s00_axis_tvalid & s00_axis_tready;
  always_comb begin
    wdata = '0;
    for (int i = 0; i < DATA_WIDTH/8; i++)
      wdata[8*i +: 8] = s00_axis_tstrb[i] ? s00_axis_tdata[8*i +: 8] : 8'h00;
  end
  // Memory has no reset so it maps onto block RAM; non-blocking read gives read-before-write.
  always_ff @(posedge s00_axis_aclk)
    if (beat) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wdata;
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn)
    if (!s00_axis_aresetn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn)
    if (!s00_axis_aresetn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s00_axis_enable) begin
          state      <= CAPTURE;
          wr_ptr     <= '0;
          overflow   <= 1'b0;
          frame_done <= 1'b0;
        end
        CAPTURE: begin
          if (beat) wr_ptr <= wr_ptr + 1'b1;
          if (!s00_axis_enable) state <= IDLE;
          else if (beat && s00_axis_tlast) begin
            state      <= DONE;
            frame_done <= 1'b1;
            frame_len  <= wr_ptr + 1'b1;
          end else if (beat && wr_ptr == (ADDR_WIDTH+1)'(MEM_SIZE-1)) begin
            state      <= DONE;
            frame_done <= 1'b1;
            overflow   <= 1'b1;
            frame_len  <= (ADDR_WIDTH+1)'(MEM_SIZE);
          end
        end
        default: if (!s00_axis_enable) begin
          state      <= IDLE;
          frame_done <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_axis_capture_mem.sv
// tb_axis_capture_mem: directed self-checking bench for axis_capture_mem.
module tb_axis_capture_mem;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] tdata = '0;
  logic [3:0]  tstrb = 4'hF;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic        rd_en = 1'b0;
  logic [11:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        frame_done;
  logic [12:0] frame_len;
  logic        overflow;
  int checks = 0;
  int failures = 0;

  axis_capture_mem dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_enable(enable),
    .s00_axis_tdata(tdata), .s00_axis_tstrb(tstrb), .s00_axis_tvalid(tvalid),
    .s00_axis_tlast(tlast), .s00_axis_tready(tready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_done(frame_done),
    .frame_len(frame_len), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l);
    tdata = d; tstrb = s; tlast = l; tvalid = 1'b1;
    tick();
    tvalid = 1'b0; tlast = 1'b0; tstrb = 4'hF;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk($sformatf("rd_valid[%0d]", a), 64'(rd_valid), 64'd1);
    chk($sformatf("rd_data[%0d]", a), 64'(rd_data), 64'(exp));
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    // 1: reset mid-capture
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_len", 64'(frame_len), 64'd0);
    enable = 1'b1;
    tick();
    chk("cap_tready", 64'(tready), 64'd1);
    for (int i = 0; i < 5; i++) send(32'h500 + 32'(i), 4'hF, 1'b0);
    tvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tready", 64'(tready), 64'd0);
    chk("mid_rst_done", 64'(frame_done), 64'd0);
    chk("mid_rst_len", 64'(frame_len), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    tvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    // 2: 8-beat frame
    tick();
    for (int i = 0; i < 8; i++) send(32'h1000 + 32'(i), 4'hF, i == 7);
    chk("t2_done", 64'(frame_done), 64'd1);
    chk("t2_len", 64'(frame_len), 64'd8);
    chk("t2_ovf", 64'(overflow), 64'd0);
    chk("t2_tready", 64'(tready), 64'd0);
    for (int i = 0; i < 8; i++) rd(12'(i), 32'h1000 + 32'(i));
    tick();
    chk("rd_valid_drop", 64'(rd_valid), 64'd0);
    chk("rd_data_hold", 64'(rd_data), 64'h1007);
    enable = 1'b0;
    tick();
    chk("t2_release_done", 64'(frame_done), 64'd0);
    chk("t2_release_len", 64'(frame_len), 64'd8);
    // 3: gapped valid
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      send(32'h2000 + 32'(i), 4'hF, i == 3);
      tdata = 32'hDEAD;
      tick();
    end
    chk("t3_len", 64'(frame_len), 64'd4);
    for (int i = 0; i < 4; i++) rd(12'(i), 32'h2000 + 32'(i));
    rd(12'd4, 32'h1004);
    enable = 1'b0;
    tick();
    // 4: byte strobes
    enable = 1'b1;
    tick();
    send(32'hAABBCCDD, 4'b0011, 1'b1);
    chk("t4_len", 64'(frame_len), 64'd1);
    rd(12'd0, 32'h0000CCDD);
    enable = 1'b0;
    tick();
    // 5: overflow
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4095; i++) send(32'(i), 4'hF, 1'b0);
    chk("t5_pre_ovf", 64'(overflow), 64'd0);
    chk("t5_pre_tready", 64'(tready), 64'd1);
    send(32'd4095, 4'hF, 1'b0);
    chk("t5_ovf", 64'(overflow), 64'd1);
    chk("t5_done", 64'(frame_done), 64'd1);
    chk("t5_len", 64'(frame_len), 64'd4096);
    chk("t5_tready", 64'(tready), 64'd0);
    send(32'hFFFFFFFF, 4'hF, 1'b0);
    chk("t5_len_after", 64'(frame_len), 64'd4096);
    rd(12'd0, 32'd0);
    rd(12'd4095, 32'd4095);
    enable = 1'b0;
    tick();
    chk("t5_ovf_hold", 64'(overflow), 64'd1);
    // 6: abort then re-arm
    enable = 1'b1;
    tick();
    chk("t6_ovf_clear", 64'(overflow), 64'd0);
    send(32'h11, 4'hF, 1'b0);
    send(32'h22, 4'hF, 1'b0);
    send(32'h33, 4'hF, 1'b0);
    enable = 1'b0;
    tick();
    chk("t6_abort_done", 64'(frame_done), 64'd0);
    chk("t6_abort_len", 64'(frame_len), 64'd4096);
    chk("t6_abort_tready", 64'(tready), 64'd0);
    enable = 1'b1;
    tick();
    rd_en = 1'b1; rd_addr = 12'd0;
    send(32'hA, 4'hF, 1'b0);
    rd_en = 1'b0;
    chk("t6_rbw", 64'(rd_data), 64'h11);
    send(32'hB, 4'hF, 1'b1);
    chk("t6_len", 64'(frame_len), 64'd2);
    chk("t6_done", 64'(frame_done), 64'd1);
    rd(12'd0, 32'hA);
    rd(12'd1, 32'hB);
    rd(12'd2, 32'h33);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
